// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - State encodings for the serial frame FSM (IDLE/START/DATA/PARITY/STOP).
//   - Default oversampling ratio of the shared baud_tick strobe.
//   - Parity helper so both directions compute the parity bit identically.
package uart_pkg;

  // baud_tick strobes per serial bit period.
  localparam int unsigned OVERSAMPLE_DEF = 16;

  // Frame FSM state encodings. They are plain constants so that older blocks
  // which carry the state as a raw vector can still compare against them.
  localparam int unsigned STATE_W   = 3;
  localparam logic [2:0]  ST_IDLE   = 3'd0;
  localparam logic [2:0]  ST_START  = 3'd1;
  localparam logic [2:0]  ST_DATA   = 3'd2;
  localparam logic [2:0]  ST_PARITY = 3'd3;
  localparam logic [2:0]  ST_STOP   = 3'd4;

  typedef logic [STATE_W-1:0] uart_state_t;

  // Parity bit over up to 8 data bits. Unused upper bits must be zero.
  // odd = 0 gives even parity (total number of ones including the parity bit
  // is even), odd = 1 gives odd parity.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts baud_tick strobes within one serial bit period.
//   A bit period is OVERSAMPLE strobes long. bit_end_c_o marks the strobe that
//   closes the period; on that clock the count wraps back to zero so the next
//   bit begins immediately. clear_i forces the count to zero and has priority
//   over counting, which lets the owner align bit periods to a state entry.
// Ports:
//   clk_i        in   system clock
//   rst_i        in   asynchronous reset, active-high
//   baud_tick_i  in   one-clock strobe, OVERSAMPLE per bit period
//   clear_i      in   synchronous clear of the tick count
//   bit_end_c_o  out  combinational: baud_tick_i & count == OVERSAMPLE-1
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic baud_tick_i,
  input  logic clear_i,
  output logic bit_end_c_o
);

  localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;
  logic          at_last;

  assign at_last     = (cnt_q == TW'(OVERSAMPLE - 1));
  assign bit_end_c_o = baud_tick_i & at_last;

  // Next count: clear wins, then count strobes and wrap at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (baud_tick_i) begin
      if (at_last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  // Tick count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_bit_timer

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
//   Accepts one data word over a valid/ready handshake and shifts out a frame:
//   start bit (0), DATA_BITS data bits LSB-first, optional parity bit, then
//   STOP_BITS stop bits (1). Bit timing comes from the shared baud_tick strobe,
//   OVERSAMPLE strobes per bit, counted from the entry into each bit.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   baud_tick  in   one-clock strobe, OVERSAMPLE per bit period
//   tx_data    in   word to send, sampled when accepted
//   tx_valid   in   tx_data is valid
//   tx_ready   out  block can accept (only while idle), registered
//   tx         out  serial line, registered, idles high
//   tx_busy    out  frame in progress, registered
//   tx_done    out  one-clock pulse as the last stop bit completes, registered
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  uart_state_t          state_q,   state_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 parity_q,  parity_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 tx_q,      tx_d;
  logic                 ready_q,   ready_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;

  logic                 accept;
  logic                 bit_end;
  logic                 timer_clear;

  assign accept = tx_valid & ready_q;

  // The tick count is held at zero while idle, so every frame's start bit is
  // timed from the accepting clock edge regardless of baud_tick phase.
  assign timer_clear = (state_q == ST_IDLE);

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk_i       (clk),
    .rst_i       (rst),
    .baud_tick_i (baud_tick),
    .clear_i     (timer_clear),
    .bit_end_c_o (bit_end)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d   = tx_data;
          parity_d  = calc_parity(8'(tx_data), (PARITY_ODD != 0));
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        // The bit counter is reused to count stop bits.
        if (bit_end) begin
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase

    // Line level for the bit that the next state will be sending.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule : uart_tx
